// File: rtl/pipe_align_shifter_if.sv
// Operand/result handshake bundle for the pipelined alignment shifter.
// The slave side is the shifter itself; the master side drives operands and consumes results.
interface pipe_align_shifter_if #(
  parameter int WIDTH = 24,
  parameter int SHW   = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_guard;
  logic             out_sticky;

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_guard, out_sticky
  );

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_guard, out_sticky
  );
endinterface

// File: rtl/pipe_align_shifter.sv
// Pipelined barrel shifter (logical/arith right, logical left, rotate right) with
// guard/sticky extraction for mantissa alignment and a globally stalled valid/ready pipe.
module pipe_align_shifter #(
  parameter int WIDTH  = 24,
  parameter int SHW    = 5,
  parameter int NSTAGE = 2
) (
  input logic               clk,
  input logic               rst_n,
  pipe_align_shifter_if.slave bus
);
  localparam int LPS = (SHW + NSTAGE - 1) / NSTAGE;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SHW-1:0]   amt;
    logic [1:0]       mode;
    logic             g;
    logic             st;
  } stg_t;

  stg_t                w_pre;
  stg_t [NSTAGE:0]     w_pipe;
  logic [NSTAGE:0]     w_vld_pipe;
  logic                w_en;
  logic                w_unused;

  // One mux level: shift by 2^k when amount bit k is set.
  function automatic stg_t mux_level(stg_t x, int k);
    stg_t             y;
    int               s;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] sh;
    logic [SHW-1:0]   am;
    y  = x;
    s  = 1 << k;
    am = x.amt >> k;
    lo = (WIDTH'(1) << (s - 1)) - WIDTH'(1);
    sh = x.d >> (s - 1);
    if (am[0]) begin
      case (x.mode)
        2'b00: begin
          y.d  = x.d >> s;
          y.g  = sh[0];
          y.st = x.st | x.g | (|(x.d & lo));
        end
        2'b01: begin
          y.d  = $signed(x.d) >>> s;
          y.g  = sh[0];
          y.st = x.st | x.g | (|(x.d & lo));
        end
        2'b10:   y.d = x.d << s;
        default: y.d = (x.d >> s) | (x.d << (WIDTH - s));
      endcase
    end
    return y;
  endfunction

  // Out-of-range amounts are folded into the operand before any mux level.
  always_comb begin
    w_pre.d    = bus.in_data;
    w_pre.amt  = bus.in_amt;
    w_pre.mode = bus.in_mode;
    w_pre.g    = 1'b0;
    w_pre.st   = 1'b0;
    if (int'(bus.in_amt) >= WIDTH) begin
      case (bus.in_mode)
        2'b00: begin
          w_pre.d   = '0;
          w_pre.amt = '0;
          w_pre.st  = |bus.in_data;
        end
        2'b01: begin
          w_pre.d   = {WIDTH{bus.in_data[WIDTH-1]}};
          w_pre.amt = '0;
          w_pre.st  = bus.in_data[WIDTH-1] | (|bus.in_data[WIDTH-2:0]);
        end
        2'b10: begin
          w_pre.d   = '0;
          w_pre.amt = '0;
        end
        default: w_pre.amt = bus.in_amt - SHW'(WIDTH);
      endcase
    end
  end

  assign w_pipe[0]     = w_pre;
  assign w_vld_pipe[0] = bus.in_valid;
  assign w_en          = bus.out_ready | ~w_vld_pipe[NSTAGE];

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stg
    stg_t w_nxt;
    stg_t r_q;
    logic r_vld;

    always_comb begin
      w_nxt = w_pipe[s];
      for (int k = 0; k < SHW; k++)
        if (k / LPS == s) w_nxt = mux_level(w_nxt, k);
    end

    // Payload only loads behind a valid token so bubbles leave the last result in place.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_q   <= '0;
      end else if (w_en) begin
        r_vld <= w_vld_pipe[s];
        if (w_vld_pipe[s]) r_q <= w_nxt;
      end
    end

    assign w_pipe[s+1]     = r_q;
    assign w_vld_pipe[s+1] = r_vld;
  end

  assign bus.in_ready   = w_en;
  assign bus.out_valid  = w_vld_pipe[NSTAGE];
  assign bus.out_data   = w_pipe[NSTAGE].d;
  assign bus.out_guard  = w_pipe[NSTAGE].g  & ~w_pipe[NSTAGE].mode[1];
  assign bus.out_sticky = w_pipe[NSTAGE].st & ~w_pipe[NSTAGE].mode[1];
  assign w_unused       = ^w_pipe[NSTAGE].amt ^ w_pipe[NSTAGE].mode[0];
endmodule

// File: tb/tb_pipe_align_shifter.sv
// Scoreboard bench for pipe_align_shifter: driver pushes expected results, monitor pops on output transfers.
module tb_pipe_align_shifter;
  localparam int W  = 24;
  localparam int SW = 5;
  localparam int NS = 2;

  typedef struct {
    logic [W-1:0] d;
    logic         g;
    logic         s;
    int           t;
    bit           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_align_shifter_if #(.WIDTH(W), .SHW(SW)) bus ();

  pipe_align_shifter #(.WIDTH(W), .SHW(SW), .NSTAGE(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Behavioural reference: whole-word shifts on the original operand.
  function automatic exp_t model(input logic [W-1:0] d, input int a, input logic [1:0] m);
    exp_t        r;
    logic [63:0] dd, sx, tmp;
    logic [W-1:0] lo;
    logic         sg;
    r.d = d; r.g = 1'b0; r.s = 1'b0; r.t = 0; r.lat = 1'b1;
    dd  = 64'(d);
    sg  = d[W-1];
    sx  = {{(64-W){sg}}, d};
    lo  = (a > 0) ? ((W'(1) << (a - 1)) - W'(1)) : '0;
    tmp = (a > 0) ? (dd >> (a - 1)) : 64'd0;
    case (m)
      2'b00, 2'b01: begin
        if (a >= W) begin
          r.d = (m == 2'b01) ? {W{sg}} : '0;
          r.s = (m == 2'b01) ? (sg | (|d[W-2:0])) : (|d);
        end else if (a > 0) begin
          r.d = (m == 2'b01) ? W'(sx >> a) : W'(dd >> a);
          r.g = tmp[0];
          r.s = |(d & lo);
        end
      end
      2'b10: r.d = (a >= W) ? '0 : W'(dd << a);
      default: begin
        tmp = {16'd0, d, d};
        r.d = W'(tmp >> ((a >= W) ? a - W : a));
      end
    endcase
    return r;
  endfunction

  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] a, input logic [1:0] m,
                      input logic [W-1:0] ed, input logic eg, input logic es, input bit lat);
    int b = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_mode  = m;
    #1;
    while (!bus.in_ready && b < 50) begin
      @(negedge clk); #1; b++;
    end
    if (!bus.in_ready) check("send_timeout", 64'd0, 64'd1);
    else q.push_back('{ed, eg, es, cyc, lat});
    @(negedge clk);
  endtask

  task automatic send_model(input logic [W-1:0] d, input logic [SW-1:0] a, input logic [1:0] m);
    exp_t e;
    e = model(d, int'(a), m);
    send(d, a, m, e.d, e.g, e.s, 1'b1);
  endtask

  task automatic drain();
    int b = 0;
    bus.in_valid = 1'b0;
    while (q.size() != 0 && b < 100) begin
      @(negedge clk); b++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compares on transfers, and checks held values while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (rst_n && bus.out_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_output: got %0h, expected no output", bus.out_data);
        end else if (bus.out_ready) begin
          e = q.pop_front();
          check("result", {bus.out_data, bus.out_guard, bus.out_sticky}, {e.d, e.g, e.s});
          if (e.lat) check("latency", 64'(cyc - e.t), 64'(NS));
        end else begin
          e = q[0];
          check("held", {bus.out_data, bus.out_guard, bus.out_sticky}, {e.d, e.g, e.s});
          check("in_ready_stall", 64'(bus.in_ready), 64'd0);
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0; bus.in_mode = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid",  64'(bus.out_valid),  64'd0);
    check("rst_data",   64'(bus.out_data),   64'd0);
    check("rst_guard",  64'(bus.out_guard),  64'd0);
    check("rst_sticky", 64'(bus.out_sticky), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, back to back
    send(24'h800001,  1, 2'b00, 24'h400000, 1'b1, 1'b0, 1'b1);
    send(24'h800013,  4, 2'b01, 24'hF80001, 1'b0, 1'b1, 1'b1);
    send(24'h000003, 30, 2'b00, 24'h000000, 1'b0, 1'b1, 1'b1);
    send(24'hF00001,  4, 2'b10, 24'h000010, 1'b0, 1'b0, 1'b1);
    send(24'h000001, 25, 2'b11, 24'h800000, 1'b0, 1'b0, 1'b1);
    send(24'h7FFFFF, 24, 2'b01, 24'h000000, 1'b0, 1'b1, 1'b1);
    send(24'h812345,  0, 2'b01, 24'h812345, 1'b0, 1'b0, 1'b1);
    send(24'h123456,  8, 2'b11, 24'h561234, 1'b0, 1'b0, 1'b1);
    send(24'h800000, 31, 2'b01, 24'hFFFFFF, 1'b0, 1'b1, 1'b1);
    send(24'h00002D,  5, 2'b00, 24'h000001, 1'b0, 1'b1, 1'b1);
    drain();

    // Back-to-back stream against the reference model
    for (int i = 0; i < 8; i++)
      send_model(W'($urandom()), SW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    drain();

    // Backpressure: two in flight, consumer stalls, garbage on idle inputs
    send(24'h0000FF, 4, 2'b00, 24'h00000F, 1'b1, 1'b1, 1'b0);
    send(24'h000123, 8, 2'b10, 24'h012300, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = 24'hABCDEF; bus.in_amt = 5'd3; bus.in_mode = 2'b01;
    repeat (4) @(negedge clk);
    bus.out_ready = 1'b1;
    drain();

    // Reset mid-stream with a result presented
    send(24'h111111, 1, 2'b00, 24'h088888, 1'b1, 1'b0, 1'b1);
    send(24'h222222, 2, 2'b00, 24'h088888, 1'b1, 1'b0, 1'b1);
    send(24'h333333, 3, 2'b00, 24'h066666, 1'b0, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("midrst_valid", 64'(bus.out_valid), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(24'h000080, 7, 2'b01, 24'h000001, 1'b0, 1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_align_shifter.md
Name: pipe_align_shifter

Overview:
- Parametrised, pipelined barrel shifter for the FPU datapath; successor to the fixed 24-bit combinational right shifter.
- Adds logical, arithmetic and rotate modes, guard/sticky extraction for mantissa alignment, and a valid/ready handshake with backpressure.
- Sits between exponent-difference logic and the mantissa adder; also serves normalisation left shifts.

Parameters:
- WIDTH, 24, data width in bits. Constraint: 2^(SHW-1) < WIDTH <= 2^SHW.
- SHW, 5, shift-amount width in bits.
- NSTAGE, 2, register stages (1..SHW). The SHW mux levels are split across stages, with ceil(SHW/NSTAGE) levels per stage and the remainder in the last stage.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  shifter can accept an operand this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SHW  shift amount.
- in_mode  in  2  00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_guard  out  1  last bit shifted out (right modes only).
- out_sticky  out  1  OR of all bits shifted out below guard (right modes only).

Behaviour:
- Reset (async, rst_n=0): all stage valid bits = 0, out_valid=0, out_data=0, out_guard=0, out_sticky=0. Pipeline contents are discarded, and in-flight operands are lost without output.
- Handshake: a transfer occurs when valid and ready are both 1 on a rising edge. in_ready = out_ready | ~out_valid (global stall). When stalled, every stage holds data and valid, and out_* stay stable until accepted.
- Latency: exactly NSTAGE cycles from input transfer to out_valid when there is no stall. Throughput is 1 operand per cycle.
- Bubbles: an empty stage still advances when in_ready=1. out_valid drops to 0 when no operand follows.
- Per-stage state: partial data, remaining amount bits, mode, guard and sticky accumulators, valid.
- Each mux level k shifts by 2^k when amount bit k is set. At each right-shift level:
  - the new guard is the lowest bit shifted out;
  - the new sticky = old sticky | old guard | OR of the other bits shifted out.
- Mode 00: zero fill from the MSB.
- Mode 01: in_data[WIDTH-1] is replicated from the MSB.
- Mode 10: zero fill from the LSB. out_guard=0 and out_sticky=0.
- Mode 11: rotate; bits leaving the LSB re-enter at the MSB. out_guard=0 and out_sticky=0.
- Out-of-range amount (in_amt >= WIDTH), resolved in stage 1 before shifting:
  - Mode 00: out_data=0, out_guard=0, out_sticky = |in_data.
  - Mode 01: out_data = all sign bits, out_guard=0, out_sticky = |in_data & ~sign ... defined precisely as OR of in_data[WIDTH-2:0] when sign=0, else 1.
  - Mode 10: out_data=0.
  - Mode 11: the effective amount is in_amt-WIDTH (valid by the parameter constraint).
- in_amt=0: out_data=in_data, out_guard=0, out_sticky=0 in all modes.
- With in_valid=0, input values are don't-care and must not disturb held stages.
- NSTAGE=1 degenerates to a single output register with the same handshake.

Test Plan:
- Reset then mode 00, in_data=0x800001, amt=1 -> after 2 cycles out_data=0x400000, guard=1, sticky=0.
- Mode 01, in_data=0x800013, amt=4 -> out_data=0xF80001, guard=0, sticky=1. Mode 00, in_data=0x000003, amt=30 -> out_data=0, guard=0, sticky=1.
- Mode 10, in_data=0xF00001, amt=4 -> out_data=0x000010, guard=0, sticky=0. Mode 11, in_data=0x000001, amt=25 -> out_data=0x800000.
- Back-to-back stream of 8 random operands with out_ready=1 -> one result per cycle, in order, each matching the reference model, latency 2.
- Two operands in flight, then out_ready=0 for 3 cycles -> in_ready=0, out_data, guard and sticky held stable; out_ready=1 -> both results drain in order with no duplicates.
- Assert rst_n=0 mid-stream (between clock edges) -> out_valid=0 immediately. On release, the first new operand yields the correct result with no stale output.
